bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 21 ++
 rtl/bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_bus_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Shared-bus bundle between four requesters and the arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface bus_arbiter_if;
    logic [3:0]  req;
    logic [31:0] src_data;
    logic [7:0]  dst;
    logic [3:0]  grant;
    logic [7:0]  bus_out;
    logic        bus_valid;
    logic [3:0]  ld_en;

    modport master (
        output req, src_data, dst,
        input  grant, bus_out, bus_valid, ld_en
    );

    modport slave (
        input  req, src_data, dst,
        output grant, bus_out, bus_valid, ld_en
    );
endinterface

// File: rtl/bus_arbiter.sv
// Four-way round-robin bus arbiter with a bounded hold time and a muxed shared data bus.
// Define ARB_TURNAROUND_EN to insert one dead cycle (grant all-zero) between owners.
module bus_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic          clk,
    input  logic          clr_n,
    bus_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
`ifdef ARB_TURNAROUND_EN
    localparam logic [1:0] ST_TURN  = 2'd2;
`endif
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    logic [1:0] state_reg, state_next;
    logic [3:0] grant_reg, grant_next;
    logic [3:0] hold_cnt_reg, hold_cnt_next;
    logic [1:0] last_winner_reg, last_winner_next;

    logic [3:0] cand;
    logic [3:0] pick;
    logic [1:0] pick_idx;
    logic       owner_live;
    logic [3:0] others;

    // Later iterations overwrite earlier ones, so k=1 (last_winner+1) has top priority.
    function automatic logic [3:0] rr_pick(input logic [3:0] c, input logic [1:0] last);
        logic [3:0] p;
        logic [1:0] idx;
        p = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (c[idx]) p = 4'(4'b0001 << idx);
        end
        return p;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int k = 0; k < 4; k++) begin
            if (oh[k]) idx = 2'(k);
        end
        return idx;
    endfunction

    assign owner_live = |(grant_reg & bus.req);
    assign others     = bus.req & ~grant_reg;
    // On a same-edge release the releasing owner is excluded from the candidates.
    assign cand       = (state_reg == ST_GRANT) ? others : bus.req;
    assign pick       = rr_pick(cand, last_winner_reg);
    assign pick_idx   = onehot_idx(pick);

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        hold_cnt_next    = hold_cnt_reg;
        last_winner_next = last_winner_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_next       = ST_GRANT;
                    grant_next       = pick;
                    hold_cnt_next    = '0;
                    last_winner_next = pick_idx;
                end
            end
            ST_GRANT: begin
                if (owner_live && (hold_cnt_reg != HOLD_LAST || others == 4'b0000)) begin
                    if (hold_cnt_reg < HOLD_LAST) hold_cnt_next = hold_cnt_reg + 4'd1;
                end else begin
`ifdef ARB_TURNAROUND_EN
                    state_next    = ST_TURN;
                    grant_next    = '0;
                    hold_cnt_next = '0;
`else
                    if (|bus.req) begin
                        grant_next       = pick;
                        hold_cnt_next    = '0;
                        last_winner_next = pick_idx;
                    end else begin
                        state_next    = ST_IDLE;
                        grant_next    = '0;
                        hold_cnt_next = '0;
                    end
`endif
                end
            end
`ifdef ARB_TURNAROUND_EN
            ST_TURN: begin
                if (|bus.req) begin
                    state_next       = ST_GRANT;
                    grant_next       = pick;
                    hold_cnt_next    = '0;
                    last_winner_next = pick_idx;
                end else begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                state_next    = ST_IDLE;
                grant_next    = '0;
                hold_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg       <= ST_IDLE;
            grant_reg       <= '0;
            hold_cnt_reg    <= '0;
            last_winner_reg <= 2'd3;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            hold_cnt_reg    <= hold_cnt_next;
            last_winner_reg <= last_winner_next;
        end
    end

    // Per-lane contributions; grant is one-hot so OR-merging the lanes is a mux.
    logic [7:0] lane_byte [4];
    logic [3:0] lane_ld   [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_byte[gi] = grant_reg[gi] ? bus.src_data[8*gi +: 8] : 8'h00;
        assign lane_ld[gi]   = grant_reg[gi] ? 4'(4'b0001 << bus.dst[2*gi +: 2]) : 4'b0000;
    end

    logic [7:0] merged_byte;
    logic [3:0] merged_ld;

    always_comb begin
        merged_byte = '0;
        merged_ld   = '0;
        for (int k = 0; k < 4; k++) begin
            merged_byte = merged_byte | lane_byte[k];
            merged_ld   = merged_ld | lane_ld[k];
        end
    end

    assign bus.grant     = grant_reg;
    assign bus.bus_valid = owner_live;
    assign bus.bus_out   = owner_live ? merged_byte : 8'h00;
    assign bus.ld_en     = owner_live ? merged_ld : 4'b0000;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expectations are queued per step and compared at the falling edge.
module tb_bus_arbiter;

`ifdef ARB_TURNAROUND_EN
    localparam bit TURN_EN = 1'b1;
`else
    localparam bit TURN_EN = 1'b0;
`endif

    logic clk;
    logic clr_n;
    bus_arbiter_if bus ();

    bus_arbiter #(.HOLD_MAX(4)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      tag;
        logic [3:0] g;
        logic       v;
        logic [7:0] o;
        logic [3:0] l;
    } exp_t;

    exp_t        sb[$];
    int          compared = 0;
    int          mism     = 0;
    logic [31:0] src_vals = 32'h773C_11A5;
    logic [7:0]  dst_vals = 8'b00_11_00_10;
    int          order [5] = '{0, 1, 2, 3, 0};

    task automatic check_all();
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            $display("txn %-10s grant=%b valid=%b out=%h ld=%b", e.tag, bus.grant, bus.bus_valid, bus.bus_out, bus.ld_en);
            compared++;
            assert (bus.grant === e.g) else begin
                mism++;
                $error("FAIL %s grant got %b want %b", e.tag, bus.grant, e.g);
            end
            compared++;
            assert (bus.bus_valid === e.v) else begin
                mism++;
                $error("FAIL %s bus_valid got %b want %b", e.tag, bus.bus_valid, e.v);
            end
            compared++;
            assert (bus.bus_out === e.o) else begin
                mism++;
                $error("FAIL %s bus_out got %h want %h", e.tag, bus.bus_out, e.o);
            end
            compared++;
            assert (bus.ld_en === e.l) else begin
                mism++;
                $error("FAIL %s ld_en got %b want %b", e.tag, bus.ld_en, e.l);
            end
        end
    endtask

    // Expected bus outputs follow from the expected grant and the bench's own req/src/dst.
    task automatic expect_grant(input string tag, input logic [3:0] g);
        exp_t e;
        e.tag = tag;
        e.g   = g;
        e.v   = |(g & bus.req);
        e.o   = 8'h00;
        e.l   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (g[i] && e.v) begin
                e.o = src_vals[8*i +: 8];
                e.l = 4'(4'b0001 << dst_vals[2*i +: 2]);
            end
        end
        sb.push_back(e);
        check_all();
    endtask

    task automatic step(input string tag, input logic [3:0] g);
        @(negedge clk);
        expect_grant(tag, g);
    endtask

    initial begin
        clr_n        = 1'b0;
        bus.req      = 4'b0000;
        bus.src_data = src_vals;
        bus.dst      = dst_vals;

        repeat (2) @(negedge clk);
        expect_grant("reset", 4'b0000);

        // Lone requester 0: one-cycle latency, then held indefinitely.
        clr_n   = 1'b1;
        bus.req = 4'b0001;
        #1 expect_grant("no_comb", 4'b0000);
        step("r0_first", 4'b0001);
        repeat (6) step("r0_hold", 4'b0001);

        bus.req = 4'b0000;
        #1 expect_grant("r0_drop", 4'b0001);
        step("r0_idle", 4'b0000);

        // Requester 2 alone, then drops: outputs masked that cycle.
        bus.req = 4'b0100;
        step("r2_grant", 4'b0100);
        bus.req = 4'b0000;
        #1 expect_grant("r2_drop", 4'b0100);
        step("r2_idle", 4'b0000);

        // Requester 0 holds while 2 pends: forced rotation after HOLD_MAX cycles.
        bus.req = 4'b0001;
        step("rot2_first", 4'b0001);
        bus.req = 4'b0101;
        repeat (3) step("rot2_hold0", 4'b0001);
        if (TURN_EN) step("rot2_turn", 4'b0000);
        repeat (4) step("rot2_hold2", 4'b0100);
        if (TURN_EN) step("rot2_turn", 4'b0000);
        step("rot2_back0", 4'b0001);

        // Asynchronous reset mid-grant.
        #2 clr_n = 1'b0;
        #1 expect_grant("async_rst", 4'b0000);
        bus.req = 4'b1000;
        @(negedge clk);
        expect_grant("rst_held", 4'b0000);
        clr_n = 1'b1;
        step("r3_grant", 4'b1000);

        // All four requesting from reset: 0,1,2,3,0 each for HOLD_MAX cycles.
        #2 clr_n = 1'b0;
        bus.req = 4'b1111;
        @(negedge clk);
        expect_grant("all_rst", 4'b0000);
        clr_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0 && TURN_EN) step("all_turn", 4'b0000);
            for (int c = 0; c < ((k == 4) ? 1 : 4); c++) begin
                step("all_rr", 4'(4'b0001 << order[k]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
